// File: rtl/spi_reg_bridge.sv
// spi_reg_bridge: turns completed SPI frames from SPI_Periphery into register
// writes/reads on a small configuration bank. The readback word for a frame is
// shifted out by SPI_Periphery during the following frame.
module spi_reg_bridge #(
  parameter int LENGTH_RECIEVED = 16,
  parameter int DATA_W          = 12,
  parameter int ADDR_W          = 3,
  parameter int SYNC_STAGES     = 2,
  parameter int SETTLE          = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  SCK,
  input  logic                  CS,
  input  logic [15:0]           COPI_register,
  output logic [15:0]           data_send,
  output logic [7*DATA_W-1:0]   cfg_regs,
  output logic                  wr_strobe,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [7:0]            err_cnt,
  output logic                  busy
);

  typedef enum logic [2:0] {
    S_DISCARD,
    S_IDLE,
    S_SHIFT,
    S_SETTLE,
    S_EXEC,
    S_HOLD
  } state_t;

  state_t                  r_state;
  logic [SYNC_STAGES-1:0]  r_sckSync;
  logic [SYNC_STAGES-1:0]  r_csSync;
  logic                    r_sckPrev;
  logic                    r_csPrev;
  logic [5:0]              r_edgeCnt;
  logic [3:0]              r_settleCnt;
  logic [15:0]             r_word;
  logic [15:0]             r_pending;
  logic [15:0]             r_dataSend;
  logic [DATA_W-1:0]       r_cfg [0:7];
  logic                    r_wrStrobe;
  logic [ADDR_W-1:0]       r_wrAddr;
  logic [7:0]              r_errCnt;

  logic                    w_csLevel;
  logic                    w_sckRise;
  logic                    w_csRise;
  logic                    w_csFall;
  logic                    w_lastEdge;
  logic                    w_isWrite;
  logic [ADDR_W-1:0]       w_addr;
  logic [DATA_W-1:0]       w_data;
  logic [DATA_W-1:0]       w_entryVal;

  // Edge detection compares the last synchronizer stage against its delayed copy.
  assign w_csLevel  = r_csSync[SYNC_STAGES-1];
  assign w_sckRise  = r_sckSync[SYNC_STAGES-1] & ~r_sckPrev;
  assign w_csRise   = w_csLevel & ~r_csPrev;
  assign w_csFall   = ~w_csLevel & r_csPrev;
  assign w_lastEdge = w_sckRise & ~w_csLevel &
                      (r_edgeCnt == 6'(LENGTH_RECIEVED - 1));

  // Fields of the captured frame word.
  assign w_isWrite = r_word[15];
  assign w_addr    = r_word[12 +: ADDR_W];
  assign w_data    = r_word[0 +: DATA_W];

  // Current value of the addressed entry; entry 7 is the status word.
  always_comb begin
    w_entryVal = r_cfg[w_addr];
    if (w_addr == {ADDR_W{1'b1}}) begin
      w_entryVal = {{(DATA_W-8){1'b0}}, r_errCnt};
    end
  end

  // Synchronizers reset low so a reset inside a frame keeps DISCARD until CS is truly high.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sckSync <= '0;
      r_csSync  <= '0;
      r_sckPrev <= 1'b0;
      r_csPrev  <= 1'b0;
    end else begin
      r_sckSync <= {r_sckSync[SYNC_STAGES-2:0], SCK};
      r_csSync  <= {r_csSync[SYNC_STAGES-2:0], CS};
      r_sckPrev <= r_sckSync[SYNC_STAGES-1];
      r_csPrev  <= r_csSync[SYNC_STAGES-1];
    end
  end

  // SCK rising-edge counter for the current frame, saturating so long frames are harmless.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_edgeCnt <= '0;
    end else if (w_csLevel) begin
      r_edgeCnt <= '0;
    end else if (w_sckRise && (r_edgeCnt != 6'd63)) begin
      r_edgeCnt <= r_edgeCnt + 6'd1;
    end
  end

  // Frame sequencing, register bank, error counter and readback staging.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_DISCARD;
      r_settleCnt <= '0;
      r_word      <= '0;
      r_pending   <= '0;
      r_dataSend  <= '0;
      r_wrStrobe  <= 1'b0;
      r_wrAddr    <= '0;
      r_errCnt    <= '0;
      for (int i = 0; i < 8; i++) begin
        r_cfg[i] <= '0;
      end
    end else begin
      r_wrStrobe <= 1'b0;
      case (r_state)
        S_DISCARD: begin
          if (w_csLevel) begin
            r_state <= S_IDLE;
          end
        end
        S_IDLE: begin
          if (w_csFall) begin
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (w_csRise) begin
            r_errCnt <= (r_errCnt == 8'hFF) ? r_errCnt : r_errCnt + 8'd1;
            r_state  <= S_IDLE;
          end else if (w_lastEdge) begin
            r_settleCnt <= '0;
            r_state     <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (w_csRise) begin
            r_errCnt <= (r_errCnt == 8'hFF) ? r_errCnt : r_errCnt + 8'd1;
            r_state  <= S_IDLE;
          end else if (r_settleCnt == 4'(SETTLE - 1)) begin
            r_word  <= COPI_register;
            r_state <= S_EXEC;
          end else begin
            r_settleCnt <= r_settleCnt + 4'd1;
          end
        end
        S_EXEC: begin
          if (w_isWrite) begin
            if (w_addr != {ADDR_W{1'b1}}) begin
              r_cfg[w_addr] <= w_data;
              r_wrStrobe    <= 1'b1;
              r_wrAddr      <= w_addr;
              r_pending     <= {1'b1, w_addr, w_data};
            end else begin
              r_errCnt  <= '0;
              r_pending <= {1'b1, w_addr, {DATA_W{1'b0}}};
            end
          end else begin
            r_pending <= {1'b0, w_addr, w_entryVal};
          end
          r_state <= S_HOLD;
        end
        S_HOLD: begin
          if (w_csLevel) begin
            r_dataSend <= r_pending;
            r_state    <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_DISCARD;
        end
      endcase
    end
  end

  // Flattened view of entries 0..6 for the PWM/control logic.
  for (genvar g = 0; g < 7; g++) begin : g_cfgFlat
    assign cfg_regs[g*DATA_W +: DATA_W] = r_cfg[g];
  end

  assign data_send = r_dataSend;
  assign wr_strobe = r_wrStrobe;
  assign wr_addr   = r_wrAddr;
  assign err_cnt   = r_errCnt;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_spi_reg_bridge.sv
// tb_spi_reg_bridge: directed frames against spi_reg_bridge with hand-computed
// expectations for the register bank, strobe, error counter and readback word.
module tb_spi_reg_bridge;

  logic        clk;
  logic        rst;
  logic        SCK;
  logic        CS;
  logic [15:0] COPI_register;
  logic [15:0] data_send;
  logic [83:0] cfg_regs;
  logic        wr_strobe;
  logic [2:0]  wr_addr;
  logic [7:0]  err_cnt;
  logic        busy;

  int compareCnt = 0;
  int failCnt    = 0;
  int strobeCycles = 0;
  int strobeBase;
  logic [2:0] lastStrobeAddr = 3'd0;

  spi_reg_bridge dut (
    .clk           (clk),
    .rst           (rst),
    .SCK           (SCK),
    .CS            (CS),
    .COPI_register (COPI_register),
    .data_send     (data_send),
    .cfg_regs      (cfg_regs),
    .wr_strobe     (wr_strobe),
    .wr_addr       (wr_addr),
    .err_cnt       (err_cnt),
    .busy          (busy)
  );

  // 100 MHz system clock; SCK is driven ten times slower by the stimulus.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Counts every cycle the strobe is high, so a stretched pulse shows up as extra cycles.
  always @(negedge clk) begin
    if (wr_strobe) begin
      strobeCycles++;
      lastStrobeAddr = wr_addr;
    end
  end

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [95:0] observed, input logic [95:0] expected);
    compareCnt++;
    assert (observed === expected) else begin
      failCnt++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic sckEdges(input int n, input logic [15:0] word);
    for (int i = 0; i < n; i++) begin
      if (i == 15) COPI_register = word;
      SCK = 1'b1;
      waitClk(5);
      SCK = 1'b0;
      waitClk(5);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] word, input int nEdges);
    CS = 1'b0;
    waitClk(6);
    sckEdges(nEdges, word);
    waitClk(10);
  endtask

  task automatic endFrame;
    CS = 1'b1;
    waitClk(10);
  endtask

  task automatic abortShort;
    CS = 1'b0;
    waitClk(4);
    sckEdges(1, 16'h0000);
    CS = 1'b1;
    waitClk(5);
  endtask

  initial begin
    logic [83:0] expCfg;
    rst = 1'b1;
    SCK = 1'b0;
    CS  = 1'b1;
    COPI_register = 16'h0000;
    expCfg = '0;

    // Reset state: DISCARD is busy, everything else cleared.
    waitClk(3);
    checkOutput("reset_busy", 96'(busy), 96'(1'b1));
    checkOutput("reset_data_send", 96'(data_send), 96'(16'h0000));
    checkOutput("reset_strobe", 96'(wr_strobe), 96'(1'b0));
    rst = 1'b0;
    waitClk(4);
    checkOutput("idle_busy", 96'(busy), 96'(1'b0));
    checkOutput("idle_cfg", 96'(cfg_regs), 96'(84'h0));
    checkOutput("idle_err", 96'(err_cnt), 96'(8'h00));
    checkOutput("idle_wr_addr", 96'(wr_addr), 96'(3'd0));

    // Write 0x9ABC: entry 1 <= 0xABC.
    strobeBase = strobeCycles;
    applyStimulus(16'h9ABC, 16);
    expCfg[23:12] = 12'hABC;
    checkOutput("wr1_cfg", 96'(cfg_regs), 96'(expCfg));
    checkOutput("wr1_entry1", 96'(cfg_regs[23:12]), 96'(12'hABC));
    checkOutput("wr1_strobe_cycles", 96'(strobeCycles - strobeBase), 96'(1));
    checkOutput("wr1_strobe_addr", 96'(lastStrobeAddr), 96'(3'd1));
    checkOutput("wr1_data_send_before_cs", 96'(data_send), 96'(16'h0000));
    checkOutput("wr1_busy_hold", 96'(busy), 96'(1'b1));
    endFrame();
    checkOutput("wr1_data_send", 96'(data_send), 96'(16'h9ABC));
    checkOutput("wr1_busy_after", 96'(busy), 96'(1'b0));

    // Read entry 1.
    strobeBase = strobeCycles;
    applyStimulus(16'h1000, 16);
    checkOutput("rd1_data_send_before_cs", 96'(data_send), 96'(16'h9ABC));
    endFrame();
    checkOutput("rd1_cfg", 96'(cfg_regs), 96'(expCfg));
    checkOutput("rd1_no_strobe", 96'(strobeCycles - strobeBase), 96'(0));
    checkOutput("rd1_data_send", 96'(data_send), 96'(16'h1ABC));

    // Abort after 10 edges, trying to write entry 2.
    applyStimulus(16'hA555, 10);
    COPI_register = 16'hA555;
    endFrame();
    checkOutput("abort_err", 96'(err_cnt), 96'(8'd1));
    checkOutput("abort_cfg", 96'(cfg_regs), 96'(expCfg));
    checkOutput("abort_data_send", 96'(data_send), 96'(16'h1ABC));

    // Status read, then clear via write to address 7.
    applyStimulus(16'h7000, 16);
    endFrame();
    checkOutput("rd7_data_send", 96'(data_send), 96'(16'h7001));
    strobeBase = strobeCycles;
    applyStimulus(16'hF000, 16);
    endFrame();
    checkOutput("wr7_err_clear", 96'(err_cnt), 96'(8'd0));
    checkOutput("wr7_data_send", 96'(data_send), 96'(16'hF000));
    checkOutput("wr7_no_strobe", 96'(strobeCycles - strobeBase), 96'(0));

    // Error counter saturation.
    for (int i = 0; i < 255; i++) abortShort();
    checkOutput("err_255", 96'(err_cnt), 96'(8'd255));
    for (int i = 0; i < 5; i++) abortShort();
    checkOutput("err_sat", 96'(err_cnt), 96'(8'd255));
    checkOutput("err_sat_data_send", 96'(data_send), 96'(16'hF000));
    applyStimulus(16'h7000, 16);
    endFrame();
    checkOutput("rd7_sat_data_send", 96'(data_send), 96'(16'h70FF));

    // Reset in the middle of a write frame, released with CS still low.
    strobeBase = strobeCycles;
    COPI_register = 16'hA555;
    applyStimulus(16'hA555, 8);
    rst = 1'b1;
    waitClk(3);
    checkOutput("midrst_cfg", 96'(cfg_regs), 96'(84'h0));
    rst = 1'b0;
    waitClk(3);
    checkOutput("midrst_busy", 96'(busy), 96'(1'b1));
    sckEdges(8, 16'hA555);
    waitClk(10);
    checkOutput("midrst_discard_busy", 96'(busy), 96'(1'b1));
    endFrame();
    expCfg = '0;
    checkOutput("midrst_busy_after", 96'(busy), 96'(1'b0));
    checkOutput("midrst_cfg_after", 96'(cfg_regs), 96'(expCfg));
    checkOutput("midrst_err", 96'(err_cnt), 96'(8'd0));
    checkOutput("midrst_data_send", 96'(data_send), 96'(16'h0000));
    checkOutput("midrst_no_strobe", 96'(strobeCycles - strobeBase), 96'(0));

    // Recovery: write the top entry.
    strobeBase = strobeCycles;
    applyStimulus(16'hE123, 16);
    endFrame();
    expCfg[83:72] = 12'h123;
    checkOutput("wr6_cfg", 96'(cfg_regs), 96'(expCfg));
    checkOutput("wr6_strobe_addr", 96'(lastStrobeAddr), 96'(3'd6));
    checkOutput("wr6_wr_addr", 96'(wr_addr), 96'(3'd6));
    checkOutput("wr6_strobe_cycles", 96'(strobeCycles - strobeBase), 96'(1));
    checkOutput("wr6_data_send", 96'(data_send), 96'(16'hE123));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCnt, failCnt);
    $finish;
  end

endmodule
